// File: rtl/complete_arbiter.sv
// Completion-stage scheduler: round-robin picks up to CDB_W finished FU results per cycle,
// applies fu_ready backpressure to the losers and registers the winners onto the CDB.
package complete_arbiter_pkg;
   localparam int FU_W   = 3;
   localparam int NUM_FU = 2 ** FU_W;
   localparam int CDB_W  = 3;
   localparam int PR_W   = 6;
   localparam int ROB_W  = 5;

   typedef struct packed {
      logic              valid;
      logic [PR_W-1:0]   dest_pr;
      logic [ROB_W-1:0]  rob_entry;
      logic [31:0]       value;
      logic              take_branch;
      logic [31:0]       target_pc;
   } fu_complete_packet_t;
endpackage

module complete_arbiter
   import complete_arbiter_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_FU-1:0]    fu_finish,
   input  fu_complete_packet_t  fu_packet [NUM_FU],
   input  logic                 squash,
   output logic [NUM_FU-1:0]    fu_ready,
   output fu_complete_packet_t  cdb_packet_out [CDB_W],
   output logic [PR_W-1:0]      cdb_t [CDB_W],
   output logic [FU_W-1:0]      rr_ptr_out
);

   localparam int CNT_W = $clog2(CDB_W + 1);
   localparam logic [CNT_W-1:0] CDB_CNT = CNT_W'(CDB_W);

   logic [FU_W-1:0]      rr_ptr;
   logic [NUM_FU-1:0]    grant;
   logic [CDB_W-1:0]     slot_valid;
   logic [FU_W-1:0]      slot_idx [CDB_W];
   logic [FU_W-1:0]      last_idx;
   logic [FU_W-1:0]      scan_idx;
   logic [CNT_W-1:0]     found;
   fu_complete_packet_t  slot_pkt [CDB_W];

   // Walk the FUs starting at the priority pointer; the k-th requester found fills slot k.
   // The pointer width equals log2(NUM_FU), so the scan index wraps 7 -> 0 for free.
   always_comb begin
      grant      = '0;
      slot_valid = '0;
      last_idx   = rr_ptr;
      scan_idx   = '0;
      found      = '0;
      for (int s = 0; s < CDB_W; s++) slot_idx[s] = '0;
      if (!reset && !squash) begin
         for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = rr_ptr + FU_W'(k);
            if (fu_finish[scan_idx] && (found < CDB_CNT)) begin
               grant[scan_idx]   = 1'b1;
               slot_valid[found] = 1'b1;
               slot_idx[found]   = scan_idx;
               last_idx          = scan_idx;
               found             = found + 1'b1;
            end
         end
      end
   end

   // Winners carry valid=1 regardless of what the FU drove; empty slots are all zero,
   // so a zero dest_pr naturally yields a zero broadcast tag.
   always_comb begin
      for (int s = 0; s < CDB_W; s++) begin
         slot_pkt[s] = '0;
         if (slot_valid[s]) begin
            slot_pkt[s]       = fu_packet[slot_idx[s]];
            slot_pkt[s].valid = 1'b1;
         end
      end
   end

   assign fu_ready   = (reset || squash) ? '1 : (~fu_finish | grant);
   assign rr_ptr_out = rr_ptr;

   // Squash and reset both flush the broadcast stage and restart priority at FU0.
   always_ff @(posedge clock) begin
      if (reset || squash) begin
         rr_ptr <= '0;
         for (int s = 0; s < CDB_W; s++) begin
            cdb_packet_out[s] <= '0;
            cdb_t[s]          <= '0;
         end
      end else begin
         for (int s = 0; s < CDB_W; s++) begin
            cdb_packet_out[s] <= slot_pkt[s];
            cdb_t[s]          <= slot_pkt[s].dest_pr;
         end
         if (|grant) rr_ptr <= last_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_complete_arbiter.sv
// Table-driven bench for complete_arbiter: each vector's expected slots/pointer go into a
// scoreboard queue at drive time and are popped and compared after the next clock edge.
module tb_complete_arbiter;
   import complete_arbiter_pkg::*;

   localparam logic [3:0] NONE = 4'hF;

   typedef struct {
      logic             rst;
      logic             sq;
      logic [7:0]       fin;
      logic [7:0]       expReady;
      logic [0:2][3:0]  expSlot;
      logic [2:0]       expPtr;
   } vec_t;

   typedef struct {
      logic [0:2][3:0]  slot;
      logic [2:0]       ptr;
      int               id;
   } exp_t;

   logic                 clock = 1'b0;
   logic                 reset;
   logic [NUM_FU-1:0]    fu_finish;
   fu_complete_packet_t  fu_packet [NUM_FU];
   logic                 squash;
   logic [NUM_FU-1:0]    fu_ready;
   fu_complete_packet_t  cdb_packet_out [CDB_W];
   logic [PR_W-1:0]      cdb_t [CDB_W];
   logic [FU_W-1:0]      rr_ptr_out;

   int   nTests = 0;
   int   nFail  = 0;
   exp_t sb [$];
   vec_t vecs [$];

   complete_arbiter dut (
      .clock          (clock),
      .reset          (reset),
      .fu_finish      (fu_finish),
      .fu_packet      (fu_packet),
      .squash         (squash),
      .fu_ready       (fu_ready),
      .cdb_packet_out (cdb_packet_out),
      .cdb_t          (cdb_t),
      .rr_ptr_out     (rr_ptr_out)
   );

   always #5 clock = ~clock;

   // FU7 models the branch unit: no destination register, so its tag must broadcast as 0.
   function automatic fu_complete_packet_t pktFor(input int i);
      fu_complete_packet_t p;
      p             = '0;
      p.dest_pr     = (i == 7) ? '0 : PR_W'(i + 7);
      p.rob_entry   = ROB_W'(i * 3 + 1);
      p.value       = 32'hC0DE_0000 + 32'(i);
      p.take_branch = (i == 7);
      p.target_pc   = 32'h0000_1000 + 32'(i * 4);
      return p;
   endfunction

   function automatic vec_t mk(input logic rst, input logic sq, input logic [7:0] fin,
                               input logic [7:0] rdy, input logic [3:0] s0,
                               input logic [3:0] s1, input logic [3:0] s2,
                               input logic [2:0] ptr);
      vec_t v;
      v.rst      = rst;
      v.sq       = sq;
      v.fin      = fin;
      v.expReady = rdy;
      v.expSlot  = {s0, s1, s2};
      v.expPtr   = ptr;
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkPkt(input string name, input fu_complete_packet_t act,
                           input fu_complete_packet_t exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t                e;
      fu_complete_packet_t ep;
      if (sb.size() == 0) begin
         nTests++;
         nFail++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
         return;
      end
      e = sb.pop_front();
      for (int s = 0; s < CDB_W; s++) begin
         ep = '0;
         if (e.slot[s] != NONE) begin
            ep       = pktFor(int'(e.slot[s]));
            ep.valid = 1'b1;
         end
         checkPkt($sformatf("v%0d slot%0d packet", e.id, s), cdb_packet_out[s], ep);
         checkVal($sformatf("v%0d cdb_t%0d", e.id, s), 64'(cdb_t[s]), 64'(ep.dest_pr));
      end
      checkVal($sformatf("v%0d rr_ptr", e.id), 64'(rr_ptr_out), 64'(e.ptr));
   endtask

   task automatic applyStimulus(input vec_t v, input int id);
      exp_t e;
      @(negedge clock);
      reset     = v.rst;
      squash    = v.sq;
      fu_finish = v.fin;
      #1;
      checkVal($sformatf("v%0d fu_ready", id), 64'(fu_ready), 64'(v.expReady));
      e.slot = v.expSlot;
      e.ptr  = v.expPtr;
      e.id   = id;
      sb.push_back(e);
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   initial begin
      reset     = 1'b1;
      squash    = 1'b0;
      fu_finish = '0;
      for (int i = 0; i < NUM_FU; i++) fu_packet[i] = pktFor(i);

      // Full load from pointer 0: three rotations, wrapping 7 -> 0
      vecs.push_back(mk(0, 0, 8'hFF, 8'h07, 0, 1, 2, 3));
      vecs.push_back(mk(0, 0, 8'hFF, 8'h38, 3, 4, 5, 6));
      vecs.push_back(mk(0, 0, 8'hFF, 8'hC1, 6, 7, 0, 1));
      // Reset mid-operation, then arbitration restarts at FU0
      vecs.push_back(mk(1, 0, 8'hFF, 8'hFF, NONE, NONE, NONE, 0));
      vecs.push_back(mk(0, 0, 8'hFF, 8'h07, 0, 1, 2, 3));
      // Squash beats fu_finish
      vecs.push_back(mk(0, 1, 8'h1E, 8'hFF, NONE, NONE, NONE, 0));
      // Single requester FU5 (dest_pr 12)
      vecs.push_back(mk(0, 0, 8'h20, 8'hFF, 5, NONE, NONE, 6));
      // Wrap from pointer 6; FU2 loses and is held, then granted next cycle
      vecs.push_back(mk(0, 0, 8'h87, 8'hFB, 7, 0, 1, 2));
      vecs.push_back(mk(0, 0, 8'h04, 8'hFF, 2, NONE, NONE, 3));
      // Idle cycle leaves the pointer alone
      vecs.push_back(mk(0, 0, 8'h00, 8'hFF, NONE, NONE, NONE, 3));
      // Two requesters fill only the low slots, in scan order
      vecs.push_back(mk(0, 0, 8'h41, 8'hFF, 6, 0, NONE, 1));
      // Branch unit with dest_pr 0 still occupies a valid slot, tag stays 0
      vecs.push_back(mk(0, 0, 8'h80, 8'hFF, 7, NONE, NONE, 0));
      // Four requesters: FU3 waits one cycle
      vecs.push_back(mk(0, 0, 8'h0F, 8'hF7, 0, 1, 2, 3));
      vecs.push_back(mk(0, 0, 8'h08, 8'hFF, 3, NONE, NONE, 4));

      repeat (2) @(posedge clock);
      #1;
      checkVal("reset fu_ready", 64'(fu_ready), 64'hFF);
      checkVal("reset rr_ptr", 64'(rr_ptr_out), 64'h0);
      for (int s = 0; s < CDB_W; s++) begin
         checkPkt($sformatf("reset slot%0d packet", s), cdb_packet_out[s], '0);
         checkVal($sformatf("reset cdb_t%0d", s), 64'(cdb_t[s]), 64'h0);
      end

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

      // Starvation bound: from pointer 4 under full load, FU3 must win within 3 cycles
      begin
         int  cyc;
         bit  won;
         won = 1'b0;
         cyc = 0;
         while (!won && cyc < 3) begin
            @(negedge clock);
            fu_finish = 8'hFF;
            #1;
            if (fu_ready[3]) won = 1'b1;
            cyc++;
         end
         nTests++;
         if (!won) begin
            nFail++;
            $display("[TB] FAIL starvation FU3: got no grant in %0d cycles, expected <= 3", cyc);
         end
         @(posedge clock);
         #1;
         checkVal("starvation rr_ptr", 64'(rr_ptr_out), 64'h5);
      end

      @(negedge clock);
      fu_finish = '0;
      checkVal("scoreboard drained", 64'(sb.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
